// File: rtl/jk_pkg.sv
// -----------------------------------------------------------------------------
// jk_pkg
//   Shared types and helpers for drivers of JK flip-flop banks.
//   - state_e     : controller FSM states (IDLE, DRIVE, CHECK)
//   - jk_code_e   : {j,k} excitation codes (HOLD, RST, SET, TGL)
//   - jk_code()   : per-bit excitation from (q, target, mask)
// -----------------------------------------------------------------------------
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Encoded as {j,k}.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_code_e;

  // Bits that are unmasked or already correct hold; everything else uses the
  // explicit set/reset form. Toggle is never produced: it depends on the
  // current Q, so a stale Q sample could flip a bit the wrong way.
  function automatic jk_code_e jk_code(input logic q, input logic t, input logic m);
    if (!m || (q == t)) return HOLD;
    return t ? SET : RST;
  endfunction

endpackage

// File: rtl/jk_bank_writer_if.sv
// -----------------------------------------------------------------------------
// jk_bank_writer_if
//   Valid/ready write-request bus into jk_bank_writer.
//   req_valid : request present               (master -> slave)
//   req_ready : slave can accept              (slave  -> master)
//   req_data  : target word, WIDTH bits       (master -> slave)
//   req_mask  : 1 = write/check bit           (master -> slave)
// -----------------------------------------------------------------------------
interface jk_bank_writer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] req_mask;

  modport master (
    output req_valid,
    output req_data,
    output req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_mask,
    output req_ready
  );
endinterface

// File: rtl/jk_excite.sv
// -----------------------------------------------------------------------------
// jk_excite
//   Combinational WIDTH-wide JK excitation encoder.
//   q_fb_i     : current Q of the bank
//   tgt_i      : desired value
//   msk_i      : 1 = bit participates, 0 = hold
//   j_next_o   : J excitation per bit
//   k_next_o   : K excitation per bit
// -----------------------------------------------------------------------------
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_fb_i,
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] msk_i,
  output logic [WIDTH-1:0] j_next_o,
  output logic [WIDTH-1:0] k_next_o
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign {j_next_o[g], k_next_o[g]} = jk_code(q_fb_i[g], tgt_i[g], msk_i[g]);
  end

endmodule

// File: rtl/jk_bank_writer.sv
// -----------------------------------------------------------------------------
// jk_bank_writer
//   Write controller for a WIDTH-bit bank of JK flops. Accepts a masked target
//   word, drives J/K excitation for one cycle, reads the bank back and retries
//   up to MAX_RETRY extra times on mismatch.
//   clk       : system clock, rising edge
//   rst       : synchronous reset, active-high
//   req       : request bus (slave side of jk_bank_writer_if)
//   q_fb      : Q outputs of the bank
//   j, k      : registered J/K inputs to the bank
//   busy      : controller is not IDLE
//   done      : one-cycle pulse, masked bank bits match the target
//   err       : one-cycle pulse, retries exhausted with a mismatch
// -----------------------------------------------------------------------------
module jk_bank_writer
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic                clk,
  input  logic                rst,
  jk_bank_writer_if.slave     req,
  input  logic [WIDTH-1:0]    q_fb,
  output logic [WIDTH-1:0]    j,
  output logic [WIDTH-1:0]    k,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // $clog2(1) is 0, so MAX_RETRY=0 still needs a 1-bit counter.
  localparam int RCW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q,   tgt_d;
  logic [WIDTH-1:0] msk_q,   msk_d;
  logic [RCW-1:0]   cnt_q,   cnt_d;
  logic [WIDTH-1:0] j_q,     j_d;
  logic [WIDTH-1:0] k_q,     k_d;
  logic             done_q,  done_d;
  logic             err_q,   err_d;

  logic [WIDTH-1:0] exc_tgt, exc_msk;
  logic [WIDTH-1:0] exc_j,   exc_k;
  logic             mismatch;

  // In IDLE the excitation is computed from the incoming request so j/k are
  // ready in the very next (DRIVE) cycle; in CHECK it uses the latched target.
  assign exc_tgt = (state_q == IDLE) ? req.req_data : tgt_q;
  assign exc_msk = (state_q == IDLE) ? req.req_mask : msk_q;

  jk_excite #(.WIDTH(WIDTH)) u_excite (
    .q_fb_i   (q_fb),
    .tgt_i    (exc_tgt),
    .msk_i    (exc_msk),
    .j_next_o (exc_j),
    .k_next_o (exc_k)
  );

  assign mismatch = |((q_fb ^ tgt_q) & msk_q);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    msk_d   = msk_q;
    cnt_d   = cnt_q;
    j_d     = '0;
    k_d     = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          tgt_d   = req.req_data;
          msk_d   = req.req_mask;
          cnt_d   = '0;
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end
      end

      // j/k defaults to zero, so they are nonzero only in DRIVE cycles.
      DRIVE: state_d = CHECK;

      CHECK: begin
        if (!mismatch) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q < RETRY_LIMIT) begin
          cnt_d   = cnt_q + RCW'(1);
          j_d     = exc_j;
          k_d     = exc_k;
          state_d = DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      msk_q   <= '0;
      cnt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      msk_q   <= msk_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign req.req_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign j             = j_q;
  assign k             = k_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_jk_bank_writer.sv
// -----------------------------------------------------------------------------
// tb_jk_bank_writer
//   Directed bench: jk_bank_writer driving 8 behavioural JK flops.
//   Cycle 0 is the cycle in which a request is presented; inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_jk_bank_writer;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] q_fb;
  logic [W-1:0] j, k;
  logic         busy, done, err;

  // Behavioural bank with async clear, a preload port and a stuck-at-0 mask.
  logic         clr_n;
  logic [W-1:0] bank;
  logic         load_en;
  logic [W-1:0] load_val;
  logic [W-1:0] stuck0;

  int n_vec;
  int n_miscmp;

  jk_bank_writer_if #(.WIDTH(W)) req_if ();

  jk_bank_writer #(.WIDTH(W), .MAX_RETRY(3)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req_if.slave),
    .q_fb (q_fb),
    .j    (j),
    .k    (k),
    .busy (busy),
    .done (done),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      bank <= '0;
    end else if (load_en) begin
      bank <= load_val;
    end else begin
      for (int i = 0; i < W; i++) begin
        case ({j[i], k[i]})
          2'b01:   bank[i] <= 1'b0;
          2'b10:   bank[i] <= 1'b1;
          2'b11:   bank[i] <= ~bank[i];
          default: bank[i] <= bank[i];
        endcase
      end
    end
  end

  assign q_fb = bank & ~stuck0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bank(input logic [W-1:0] v);
    load_val = v;
    load_en  = 1'b1;
    step();
    load_en  = 1'b0;
  endtask

  task automatic present(input logic [W-1:0] d, input logic [W-1:0] m);
    req_if.req_valid = 1'b1;
    req_if.req_data  = d;
    req_if.req_mask  = m;
  endtask

  initial begin
    n_vec            = 0;
    n_miscmp         = 0;
    clr_n            = 1'b1;
    load_en          = 1'b0;
    load_val         = '0;
    stuck0           = '0;
    rst              = 1'b1;
    req_if.req_valid = 1'b0;
    req_if.req_data  = '0;
    req_if.req_mask  = '0;

    // ---------------- reset values ----------------
    repeat (3) step();
    check("rst_ready", 32'(req_if.req_ready), 32'd1);
    check("rst_busy",  32'(busy),             32'd0);
    check("rst_j",     32'(j),                32'h00);
    check("rst_k",     32'(k),                32'h00);
    check("rst_done",  32'(done),             32'd0);
    check("rst_err",   32'(err),              32'd0);
    rst = 1'b0;
    step();

    // ---------------- 00 -> A5, full mask ----------------
    load_bank(8'h00);
    present(8'hA5, 8'hFF);
    check("t1_c0_ready", 32'(req_if.req_ready), 32'd1);
    step(); req_if.req_valid = 1'b0;
    check("t1_c1_j",    32'(j),    32'hA5);
    check("t1_c1_k",    32'(k),    32'h00);
    check("t1_c1_busy", 32'(busy), 32'd1);
    step();
    check("t1_c2_q",    32'(q_fb), 32'hA5);
    check("t1_c2_j",    32'(j),    32'h00);
    step();
    check("t1_c3_done",  32'(done),             32'd1);
    check("t1_c3_err",   32'(err),              32'd0);
    check("t1_c3_ready", 32'(req_if.req_ready), 32'd1);
    step();
    check("t1_c4_done", 32'(done), 32'd0);

    // ---------------- F0 -> 0F under mask 3C ----------------
    load_bank(8'hF0);
    present(8'h0F, 8'h3C);
    step(); req_if.req_valid = 1'b0;
    check("t2_c1_j", 32'(j), 32'h0C);
    check("t2_c1_k", 32'(k), 32'h30);
    step();
    check("t2_c2_q", 32'(q_fb), 32'hCC);
    step();
    check("t2_c3_done", 32'(done), 32'd1);
    check("t2_c3_q",    32'(q_fb), 32'hCC);

    // ---------------- bit 0 stuck at 0, retries exhaust ----------------
    load_bank(8'h00);
    stuck0 = 8'h01;
    present(8'h01, 8'h01);
    step(); req_if.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (c % 2 == 1) begin
        check($sformatf("t3_c%0d_j", c), 32'(j), 32'h01);
      end else begin
        check($sformatf("t3_c%0d_j", c), 32'(j), 32'h00);
      end
      check($sformatf("t3_c%0d_busy", c), 32'(busy), 32'd1);
      check($sformatf("t3_c%0d_done", c), 32'(done), 32'd0);
      check($sformatf("t3_c%0d_err",  c), 32'(err),  32'd0);
      step();
    end
    check("t3_c9_err",  32'(err),  32'd1);
    check("t3_c9_done", 32'(done), 32'd0);
    check("t3_c9_busy", 32'(busy), 32'd0);
    step();
    check("t3_c10_err", 32'(err), 32'd0);
    stuck0 = 8'h00;

    // ---------------- already equal, valid held through busy ----------------
    load_bank(8'h5A);
    present(8'h5A, 8'hFF);
    step();
    check("t4_c1_j",     32'(j),                32'h00);
    check("t4_c1_k",     32'(k),                32'h00);
    check("t4_c1_ready", 32'(req_if.req_ready), 32'd0);
    step();
    check("t4_c2_ready", 32'(req_if.req_ready), 32'd0);
    check("t4_c2_done",  32'(done),             32'd0);
    step();
    check("t4_c3_done",  32'(done),             32'd1);
    check("t4_c3_ready", 32'(req_if.req_ready), 32'd1);
    step(); req_if.req_valid = 1'b0;
    check("t4_c4_busy", 32'(busy), 32'd1);
    step(); step();
    check("t4_c6_done", 32'(done), 32'd1);
    step();

    // ---------------- reset during CHECK ----------------
    load_bank(8'h00);
    present(8'h0F, 8'hFF);
    step(); req_if.req_valid = 1'b0;
    step();
    check("t5_c2_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check("t5_c3_busy",  32'(busy),             32'd0);
    check("t5_c3_ready", 32'(req_if.req_ready), 32'd1);
    check("t5_c3_j",     32'(j),                32'h00);
    check("t5_c3_k",     32'(k),                32'h00);
    check("t5_c3_done",  32'(done),             32'd0);
    check("t5_c3_err",   32'(err),              32'd0);
    step();
    check("t5_c4_done", 32'(done), 32'd0);
    check("t5_c4_err",  32'(err),  32'd0);
    // Bank already holds 0F from the aborted request's DRIVE cycle.
    present(8'h3C, 8'hFF);
    step(); req_if.req_valid = 1'b0;
    check("t5b_c1_j", 32'(j), 32'h30);
    check("t5b_c1_k", 32'(k), 32'h03);
    step(); step();
    check("t5b_c3_done", 32'(done), 32'd1);
    check("t5b_c3_q",    32'(q_fb), 32'h3C);

    // ---------------- back-to-back 11 then 22 ----------------
    present(8'h11, 8'hFF);
    step();
    req_if.req_data = 8'h22;
    check("t6_c1_j", 32'(j), 32'h01);
    check("t6_c1_k", 32'(k), 32'h2C);
    step();
    check("t6_c2_q", 32'(q_fb), 32'h11);
    step();
    check("t6_c3_done",  32'(done),             32'd1);
    check("t6_c3_ready", 32'(req_if.req_ready), 32'd1);
    step(); req_if.req_valid = 1'b0;
    check("t6_c4_j", 32'(j), 32'h22);
    check("t6_c4_k", 32'(k), 32'h11);
    step(); step();
    check("t6_c6_done", 32'(done), 32'd1);
    check("t6_c6_err",  32'(err),  32'd0);
    check("t6_c6_q",    32'(q_fb), 32'h22);
    step();
    check("t6_c7_done", 32'(done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/jk_bank_writer.md
# jk_bank_writer

Write controller for a bank of JK flip-flops. It accepts a target word over a valid/ready request and derives per-bit J/K excitation from the bank's current Q feedback. It drives that excitation for one clock, then reads the bank back to confirm the write, retrying on mismatch. It sits between a register-write master and a WIDTH-bit array of JK flops, and is the only source of their j/k inputs.

## Interface
- WIDTH, 8, bits in the JK bank
- MAX_RETRY, 3, extra drive attempts after the first failed check (0 = single attempt)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high exactly when state is IDLE
- req_data  in  WIDTH  target value
- req_mask  in  WIDTH  1 = bit is written and checked; 0 = bit held and ignored
- q_fb  in  WIDTH  Q outputs of the JK bank
- j  out  WIDTH  J inputs to the bank, registered
- k  out  WIDTH  K inputs to the bank, registered
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse: masked bits of q_fb equal the target
- err  out  1  one-cycle pulse: retries exhausted with a mismatch

## Operation
- States: IDLE, DRIVE, CHECK.
- **IDLE**
  - Accept on req_valid & req_ready.
  - Latch req_data into tgt and req_mask into msk.
  - Clear retry_cnt.
  - Register j/k from the excitation of the current q_fb.
  - Go to DRIVE.
- **Excitation, per bit**
  - msk=0 or q_fb==tgt: j=0, k=0 (hold).
  - Otherwise: j=tgt, k=~tgt (set or reset form).
  - j=k=1 (toggle) is never issued.
- **DRIVE**
  - j/k are stable for this whole cycle; the bank captures them at its end.
  - Next state is CHECK, with j/k registered to 0.
- **CHECK**
  - Compare (q_fb ^ tgt) & msk.
  - Zero: pulse done next cycle, go to IDLE.
  - Nonzero and retry_cnt < MAX_RETRY: increment retry_cnt, register fresh excitation from the current q_fb, go to DRIVE.
  - Nonzero and retry_cnt == MAX_RETRY: pulse err next cycle, go to IDLE.
- retry_cnt width is $clog2(MAX_RETRY+1), minimum 1. It never wraps: saturation is prevented by the compare above.
- tgt and msk do not change while busy. req_valid is ignored while busy (req_ready=0).
- **Reset values:** state IDLE, j=0, k=0, done=0, err=0, busy=0, req_ready=1, retry_cnt=0, tgt=0, msk=0.
- **Reset mid-operation:** next cycle is IDLE, j/k are 0, and no done/err pulse is issued for the aborted request.

## Timing
- Accept at edge of cycle 0; j/k valid in cycle 1 (DRIVE); CHECK in cycle 2; done/err high in cycle 3.
- req_ready returns high in cycle 3, so the next accept can occur at the end of cycle 3.
- Per retry: +2 cycles. Worst case, error pulse in cycle 3 + 2·MAX_RETRY.
- j/k are nonzero only in DRIVE cycles.
- done and err are never high together, and each is high only in the first IDLE cycle after CHECK.
- All-zero mask, or target already equal to q_fb:
  - Full DRIVE/CHECK sequence with j=k=0, done in cycle 3.
  - No shortcut path.

## Structure
- **Package jk_pkg**
  - State enum (IDLE, DRIVE, CHECK).
  - JK code constants: HOLD=2'b00, RST=2'b01, SET=2'b10, TGL=2'b11.
  - Function mapping (q, target, mask) → {j,k}.
- **Sub-module jk_excite**
  - Combinational WIDTH-wide encoder: q_fb, tgt, msk → j_next, k_next.
  - Reusable by any future JK-bank driver.
- The controller instantiates one jk_excite and holds the FSM, registers and retry counter.

## Test plan
- Bench wraps the DUT around 8 behavioural JK flops with async clear held inactive.
- **Bank 8'h00, req_data 8'hA5, mask 8'hFF, accept cycle 0**
  - Cycle 1: j=8'hA5, k=8'h00.
  - Cycle 2: q_fb=8'hA5.
  - Cycle 3: done=1, err=0.
- **Bank 8'hF0, req_data 8'h0F, mask 8'h3C**
  - Cycle 1: j=8'h0C, k=8'h30.
  - Bank ends 8'hCC, done in cycle 3.
- **Bank bit 0 forced stuck at 0, req 8'h01/8'h01, MAX_RETRY=3**
  - DRIVE occurs in cycles 1, 3, 5, 7, each with j=8'h01.
  - err=1 in cycle 9, done never asserted.
- **Bank 8'h5A, req 8'h5A**
  - Cycle 1: j=k=0.
  - Cycle 3: done.
  - req_valid held high through cycles 1–3 is not accepted until req_ready at cycle 3.
- **rst asserted in cycle 2 (CHECK) of a request**
  - Cycle 3: IDLE, j=k=0, busy=0.
  - No done/err pulse.
  - A new request is accepted normally afterwards.
- **Back-to-back requests 8'h11 then 8'h22, both mask 8'hFF, req_valid held high**
  - Accepts occur at cycles 0 and 3.
  - done pulses in cycles 3 and 6.
  - Bank ends 8'h22.
